serial_paralelo_rx: RTL and testbench

//  Receive side of the PHY link. Deserializes the 1-bit stream produced by the parallel-to-serial transmitter.

---
 rtl/phy_pkg.sv | 20 ++
 rtl/rx_deser.sv | 36 +++
 rtl/serial_paralelo_rx.sv | 147 ++++++++++++++
 tb/tb_serial_paralelo_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phy_pkg
// Description : Shared PHY link constants and state encoding (TX and RX).
// Revision    : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam int         c_byte_w = 8;
    localparam logic [7:0] c_com    = 8'hBC;
    localparam logic [7:0] c_idl    = 8'h7C;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } phy_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : rx_deser
// Description : Serial shift register, bit counter and byte-boundary detect.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_deser
    import phy_pkg::*;
(
    input  logic                clk_32f,
    input  logic                reset,
    input  logic                i_data,
    input  logic                i_hold,
    output logic [c_byte_w-1:0] o_nxt,
    output logic                o_boundary
);

    // Only the low seven bits are ever reused, so the MSB is not stored.
    logic [c_byte_w-2:0] r_sr;
    logic [2:0]          r_bit_cnt;

    assign o_nxt      = {r_sr, i_data};
    assign o_boundary = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_sr      <= '0;
            r_bit_cnt <= 3'd0;
        end else begin
            r_sr      <= o_nxt[c_byte_w-2:0];
            r_bit_cnt <= i_hold ? 3'd0 : r_bit_cnt + 3'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_rx
// Description : PHY receive deserializer with COM alignment and lock FSM.
//               Optional COM_CNT_EN adds a saturating locked-COM counter.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter logic [7:0] COM    = c_com,
    parameter logic [7:0] IDL    = c_idl,
    parameter int         LOCK_N = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
`ifdef COM_CNT_EN
    output logic [7:0] com_count,
`endif
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active,
    output logic       IDLE_OUT
);

    localparam logic [4:0] c_lock_n = 5'(LOCK_N);

    phy_state_t    r_state, w_state_nxt;
    logic [3:0]    r_lock_cnt, w_lock_cnt_nxt;
    logic [4:0]    w_lock_inc;
    logic [7:0]    w_nxt;
    logic          w_boundary;
    logic          w_is_com;
    logic          w_capture;
    logic          w_b_ctrl;

    logic [7:0]    r_b;
    logic          r_b_pend;
    logic [7:0]    r_data_out;
    logic          r_valid_out;
    logic          r_byte_stb;
    logic          r_active;
    logic          r_idle_out;

    rx_deser u_deser (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .i_data     (data_in),
        .i_hold     (r_state == HUNT),
        .o_nxt      (w_nxt),
        .o_boundary (w_boundary)
    );

    assign w_is_com   = (w_nxt == COM);
    assign w_lock_inc = {1'b0, r_lock_cnt} + 5'd1;
    assign w_capture  = (r_state == LOCKED) && w_boundary;
    assign w_b_ctrl   = (r_b == COM) || (r_b == IDL);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state    <= HUNT;
            r_lock_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            HUNT: begin
                if (w_is_com) begin
                    w_state_nxt    = ALIGN;
                    w_lock_cnt_nxt = 4'd1;
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_lock_cnt_nxt = w_lock_inc[3:0];
                        if (w_lock_inc == c_lock_n)
                            w_state_nxt = LOCKED;
                    end else begin
                        w_state_nxt    = HUNT;
                        w_lock_cnt_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                w_state_nxt = LOCKED;
            end
            default: begin
                w_state_nxt    = HUNT;
                w_lock_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Byte captured at the boundary, presented one edge later.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_b         <= 8'd0;
            r_b_pend    <= 1'b0;
            r_data_out  <= 8'd0;
            r_valid_out <= 1'b0;
            r_byte_stb  <= 1'b0;
            r_active    <= 1'b0;
            r_idle_out  <= 1'b0;
        end else begin
            r_b_pend    <= w_capture;
            if (w_capture)
                r_b <= w_nxt;
            r_byte_stb  <= r_b_pend;
            r_valid_out <= r_b_pend && !w_b_ctrl;
            if (r_b_pend && !w_b_ctrl)
                r_data_out <= r_b;
            if (r_b_pend)
                r_idle_out <= (r_b == IDL);
            r_active    <= (r_state == LOCKED);
        end
    end

`ifdef COM_CNT_EN
    logic [7:0] r_com_count;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)
            r_com_count <= 8'd0;
        else if (r_b_pend && (r_b == COM) && (r_com_count != 8'hFF))
            r_com_count <= r_com_count + 8'd1;
    end

    assign com_count = r_com_count;
`endif

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign byte_stb  = r_byte_stb;
    assign active    = r_active;
    assign IDLE_OUT  = r_idle_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo_rx
// Description : Directed scoreboard bench for serial_paralelo_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       active;
    logic       IDLE_OUT;
`ifdef COM_CNT_EN
    logic [7:0] com_count;
`endif

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       idle;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_last   = 8'd0;
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         last_stb = -1;

    serial_paralelo_rx dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
`ifdef COM_CNT_EN
        .com_count (com_count),
`endif
        .data_out  (data_out),
        .valid_out (valid_out),
        .byte_stb  (byte_stb),
        .active    (active),
        .IDLE_OUT  (IDLE_OUT)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},   data_out,  0);
        chk({tag, "_valid"},  valid_out, 0);
        chk({tag, "_stb"},    byte_stb,  0);
        chk({tag, "_active"}, active,    0);
        chk({tag, "_idle"},   IDLE_OUT,  0);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
    endtask

    // push: byte lands on a LOCKED boundary; chk_act: probe active one and two edges after the previous byte
    task automatic send_byte(input logic [7:0] b, input bit push,
                             input bit chk_act, input logic exp0, input logic exp1);
        exp_t e;
        if (push) begin
            if (b != 8'hBC && b != 8'h7C)
                m_last = b;
            e.data  = m_last;
            e.valid = (b != 8'hBC) && (b != 8'h7C);
            e.idle  = (b == 8'h7C);
            sb.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_32f);
            if (chk_act && i == 0) chk("active_t0", active, exp0);
            if (chk_act && i == 1) chk("active_t1", active, exp1);
            data_in = b[7-i];
        end
    endtask

    always @(negedge clk_32f) begin
        exp_t e;
        cyc++;
        if (reset === 1'b1) begin
            if (byte_stb === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("stb_unexpected", byte_stb, 0);
                end else begin
                    e = sb.pop_front();
                    chk("data_out",  data_out,  e.data);
                    chk("valid_out", valid_out, e.valid);
                    chk("idle_out",  IDLE_OUT,  e.idle);
                    if (last_stb >= 0)
                        chk("stb_gap", cyc - last_stb, 8);
                    last_stb = cyc;
                end
            end else begin
                chk("valid_no_stb", valid_out, 0);
            end
        end
    end

    initial begin
        // reset held low, then released with idle line
        #1 reset = 1'b0;
        repeat (100) @(negedge clk_32f);
        chk_all_zero("in_reset");
`ifdef COM_CNT_EN
        chk("com_count_reset", com_count, 0);
`endif
        reset = 1'b1;
        repeat (5) send_bit(1'b0);
        chk_all_zero("post_reset");

        // random prefix then four COMs to lock
        repeat (3) send_bit(1'($urandom_range(0, 1)));
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hFF, 1, 1, 0, 1);
        send_byte(8'hEE, 1, 1, 1, 1);
        send_byte(8'hDD, 1, 0, 0, 0);
        send_byte(8'hCC, 1, 0, 0, 0);

        // control symbols hold data_out
        send_byte(8'h7C, 1, 0, 0, 0);
        send_byte(8'h7C, 1, 0, 0, 0);
        send_byte(8'hBC, 1, 0, 0, 0);
        send_byte(8'h77, 1, 0, 0, 0);
        repeat (3) send_bit(1'b0);
        chk("sb_drained_1", sb.size(), 0);
        chk("locked_active", active, 1);
        chk("locked_data", data_out, 8'h77);

        // asynchronous reset between clock edges
        #2 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        sb.delete();
        m_last   = 8'd0;
        last_stb = -1;
        repeat (4) @(negedge clk_32f);
        reset = 1'b1;

        // broken COM run restarts the lock count
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'h3A, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'hBC, 0, 1, 0, 0);
        send_byte(8'h55, 1, 1, 0, 1);
`ifdef COM_CNT_EN
        for (int k = 0; k < 300; k++)
            send_byte(8'hBC, 1, 0, 0, 0);
`endif
        send_byte(8'h7C, 1, 0, 0, 0);
        repeat (3) send_bit(1'b0);
        chk("sb_drained_2", sb.size(), 0);
        chk("relock_active", active, 1);
        chk("relock_idle", IDLE_OUT, 1);
        chk("relock_data", data_out, 8'h55);
`ifdef COM_CNT_EN
        chk("com_count_sat", com_count, 8'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
